// File: rtl/vga_swap_frame_buffer_if.sv
// VGA timing bundle shared by the frame buffer's input timing stream and its pixel output.
// The input side carries timing only; any rgb on the incoming stream is ignored.
interface vga_if #(
    parameter int COLOR_W = 12
);
    logic [10:0]        hcount;
    logic [10:0]        vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [COLOR_W-1:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_swap_frame_buffer.sv
// Double-buffered frame store: renderer writes the back buffer, VGA reads the upscaled front buffer.
// Define CLEAR_ON_SWAP_EN to sweep the new back buffer with CLEAR_COLOR after every swap.
module vga_swap_frame_buffer #(
    parameter int                 FB_W        = 200,
    parameter int                 FB_H        = 150,
    parameter int                 SCALE_SHIFT = 2,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_if.in                       in,
    vga_if.out                      out,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(FB_W)-1:0] wr_x,
    input  logic [$clog2(FB_H)-1:0] wr_y,
    input  logic [COLOR_W-1:0]      wr_rgb,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    front_sel
);
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_WRITE, ST_PENDING, ST_CLEAR} state_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    state_t             state_q, state_d;
    logic               front_sel_q, front_sel_d;
    logic               swap_ack_q, swap_ack_d;
    logic               wr_ready_q, wr_ready_d;
    logic               vblnk_prev_q, vblnk_prev_d;
    logic               swap_fire;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;
`ifdef CLEAR_ON_SWAP_EN
    logic [AW-1:0]      clr_addr_q, clr_addr_d;
`endif

    timing_t            t_in, t_s1_q, t_s1_d, t_s2_q, t_s2_d;
    logic [10:0]        rd_x, rd_y;
    logic [AW-1:0]      rd_addr;
    logic               in_range_q, in_range_d;
    logic               rd_sel_q, rd_sel_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;

    // Buffer gi is written only while it is the back buffer; both are read every cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : buf_g
            logic [COLOR_W-1:0] mem [DEPTH];
            logic [COLOR_W-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (mem_we && (front_sel_q != 1'(gi))) begin
                    mem[mem_waddr] <= mem_wdata;
                end
                rd_data_q <= mem[rd_addr];
            end
        end
    endgenerate

    always_comb begin
        t_in       = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk};
        rd_x       = in.hcount >> SCALE_SHIFT;
        rd_y       = in.vcount >> SCALE_SHIFT;
        in_range_d = (int'(rd_x) < FB_W) && (int'(rd_y) < FB_H);
        rd_addr    = in_range_d ? AW'(int'(rd_y) * FB_W + int'(rd_x)) : '0;
        rd_sel_d   = front_sel_q;
        t_s1_d     = t_in;
        t_s2_d     = t_s1_q;
        rgb_d      = '0;
        if (!t_s1_q.hblnk && !t_s1_q.vblnk && in_range_q) begin
            rgb_d = rd_sel_q ? buf_g[1].rd_data_q : buf_g[0].rd_data_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_sel_d  = front_sel_q;
        swap_ack_d   = 1'b0;
        vblnk_prev_d = in.vblnk;
        swap_fire    = 1'b0;
        mem_we       = wr_valid && wr_ready_q && (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
        mem_waddr    = AW'(int'(wr_y) * FB_W + int'(wr_x));
        mem_wdata    = wr_rgb;
`ifdef CLEAR_ON_SWAP_EN
        clr_addr_d   = clr_addr_q;
`endif
        case (state_q)
            ST_WRITE: begin
                if (swap_req) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (in.vblnk && !vblnk_prev_q) begin
                    swap_fire   = 1'b1;
                    front_sel_d = ~front_sel_q;
                    swap_ack_d  = 1'b1;
`ifdef CLEAR_ON_SWAP_EN
                    state_d     = ST_CLEAR;
                    clr_addr_d  = '0;
`else
                    state_d     = ST_WRITE;
`endif
                end
            end
`ifdef CLEAR_ON_SWAP_EN
            ST_CLEAR: begin
                // The swap_ack cycle is spent idle so the sweep ends FB_W*FB_H+1 cycles later.
                if (!swap_ack_q) begin
                    mem_we     = 1'b1;
                    mem_waddr  = clr_addr_q;
                    mem_wdata  = CLEAR_COLOR;
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == AW'(DEPTH - 1)) state_d = ST_WRITE;
                end
            end
`endif
            default: state_d = ST_WRITE;
        endcase
        wr_ready_d = (state_d == ST_WRITE) && !swap_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WRITE;
            front_sel_q  <= 1'b0;
            swap_ack_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            vblnk_prev_q <= 1'b1;
            t_s1_q       <= '0;
            t_s2_q       <= '0;
            in_range_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            rgb_q        <= '0;
`ifdef CLEAR_ON_SWAP_EN
            clr_addr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            swap_ack_q   <= swap_ack_d;
            wr_ready_q   <= wr_ready_d;
            vblnk_prev_q <= vblnk_prev_d;
            t_s1_q       <= t_s1_d;
            t_s2_q       <= t_s2_d;
            in_range_q   <= in_range_d;
            rd_sel_q     <= rd_sel_d;
            rgb_q        <= rgb_d;
`ifdef CLEAR_ON_SWAP_EN
            clr_addr_q   <= clr_addr_d;
`endif
        end
    end

    assign out.hcount = t_s2_q.hcount;
    assign out.vcount = t_s2_q.vcount;
    assign out.hsync  = t_s2_q.hsync;
    assign out.vsync  = t_s2_q.vsync;
    assign out.hblnk  = t_s2_q.hblnk;
    assign out.vblnk  = t_s2_q.vblnk;
    assign out.rgb    = rgb_q;
    assign wr_ready   = wr_ready_q;
    assign swap_ack   = swap_ack_q;
    assign front_sel  = front_sel_q;
endmodule
